// File: rtl/direction_scheduler.sv
// direction_scheduler: walks the 8 compass directions around a candidate
// square through an external single-direction validator, collects the
// per-direction capture mask, and shares the single board-RAM port with a
// host requester that owns it whenever no scan is running.
module direction_scheduler #(
    parameter int ROW_STRIDE = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] s_addr,
    input  logic       player,
    output logic       busy,
    output logic       done,
    output logic       legal,
    output logic [7:0] dir_mask,
    output logic       timeout_err,
    output logic       vld_ld,
    output logic [6:0] vld_step,
    output logic       vld_start,
    input  logic       vld_status,
    input  logic       vld_done,
    input  logic [6:0] vld_addr,
    input  logic       vld_wren,
    input  logic       host_req,
    input  logic [6:0] host_addr,
    input  logic       host_wren,
    output logic       host_grant,
    output logic [6:0] mem_addr,
    output logic       mem_wren,
    input  logic [1:0] mem_data
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CHECK_ADDR, CHECK_DATA, LOAD_DIR,
        START_DIR, WAIT_DIR, NEXT_DIR, FINISH
    } state_t;

    // Row/column offsets of the 8 neighbours, in direction-index order.
    localparam int ROW_OFF [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int COL_OFF [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    logic [6:0] step_table [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_step
        assign step_table[gi] = 7'(ROW_OFF[gi] * ROW_STRIDE + COL_OFF[gi]);
    end

    state_t          state_reg, state_next;
    logic [2:0]      idx_reg, idx_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [7:0]      mask_reg, mask_next;
    logic            legal_reg, legal_next;
    logic            terr_reg, terr_next;
    logic [6:0]      step_reg, step_next;
    logic            pending_reg, pending_next;
    logic [6:0]      addr_reg, addr_next;
    logic            accept;

    // player goes straight to the validator elsewhere, and validator-side
    // writes are never passed to the board during a scan.
    logic unused_inputs;
    assign unused_inputs = player ^ vld_wren;

    assign busy        = (state_reg != IDLE) && (state_reg != FINISH);
    assign done        = (state_reg == FINISH);
    assign vld_ld      = (state_reg == LOAD_DIR);
    assign vld_start   = (state_reg == START_DIR);
    assign legal       = legal_reg;
    assign dir_mask    = mask_reg;
    assign timeout_err = terr_reg;
    assign vld_step    = step_reg;
    assign accept      = (state_reg == IDLE) && pending_reg && !host_req;

    // Board RAM port mux: host owns it in IDLE, the scan owns it otherwise.
    always_comb begin
        host_grant = 1'b0;
        mem_addr   = vld_addr;
        mem_wren   = 1'b0;
        if (state_reg == IDLE) begin
            host_grant = host_req & reset;
            mem_addr   = host_addr;
            mem_wren   = host_wren & reset;
        end else if (state_reg == CHECK_ADDR) begin
            mem_addr = addr_reg;
        end
    end

    // Next-state logic for the scan sequencer and its datapath registers.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        count_next   = count_reg;
        mask_next    = mask_reg;
        legal_next   = legal_reg;
        terr_next    = terr_reg;
        step_next    = step_reg;
        pending_next = pending_reg;
        addr_next    = addr_reg;

        // A start in the accept cycle would clobber the address about to be
        // used, so it is treated like a start while busy.
        if (start && !busy && !accept) begin
            pending_next = 1'b1;
            addr_next    = s_addr;
        end

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next   = CHECK_ADDR;
                    pending_next = 1'b0;
                    mask_next    = 8'h00;
                    terr_next    = 1'b0;
                    legal_next   = 1'b0;
                end
            end
            CHECK_ADDR: state_next = CHECK_DATA;
            CHECK_DATA: begin
                if (mem_data != 2'b00) begin
                    state_next = FINISH;
                    legal_next = 1'b0;
                end else begin
                    idx_next   = 3'd0;
                    step_next  = step_table[0];
                    state_next = LOAD_DIR;
                end
            end
            LOAD_DIR: begin
                count_next = '0;
                state_next = START_DIR;
            end
            START_DIR: state_next = WAIT_DIR;
            WAIT_DIR: begin
                if (vld_done) begin
                    mask_next[idx_reg] = vld_status;
                    state_next         = NEXT_DIR;
                end else if (count_reg == CW'(TIMEOUT - 1)) begin
                    mask_next[idx_reg] = 1'b0;
                    terr_next          = 1'b1;
                    state_next         = NEXT_DIR;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            NEXT_DIR: begin
                if (idx_reg == 3'd7) begin
                    legal_next = |mask_reg;
                    state_next = FINISH;
                end else begin
                    idx_next   = idx_reg + 3'd1;
                    step_next  = step_table[idx_reg + 3'd1];
                    state_next = LOAD_DIR;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            idx_reg     <= 3'd0;
            count_reg   <= '0;
            mask_reg    <= 8'h00;
            legal_reg   <= 1'b0;
            terr_reg    <= 1'b0;
            step_reg    <= 7'd0;
            pending_reg <= 1'b0;
            addr_reg    <= 7'd0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            count_reg   <= count_next;
            mask_reg    <= mask_next;
            legal_reg   <= legal_next;
            terr_reg    <= terr_next;
            step_reg    <= step_next;
            pending_reg <= pending_next;
            addr_reg    <= addr_next;
        end
    end

endmodule

// File: tb/tb_direction_scheduler.sv
// Testbench for direction_scheduler: board RAM and validator models, with a
// scoreboard of expected step values and scan results.
module tb_direction_scheduler;

    localparam int LAT = 2;
    localparam int TMO = 15;

    logic       clock = 1'b0;
    logic       reset, start, player;
    logic [6:0] s_addr;
    logic       busy, done, legal, timeout_err, vld_ld, vld_start;
    logic [7:0] dir_mask;
    logic [6:0] vld_step;
    logic       vld_status, vld_done;
    logic [6:0] vld_addr;
    logic       vld_wren, host_req, host_wren, host_grant, mem_wren;
    logic [6:0] host_addr, mem_addr;
    logic [1:0] mem_data;

    always #5 clock = ~clock;

    direction_scheduler #(.ROW_STRIDE(10), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .start(start), .s_addr(s_addr),
        .player(player), .busy(busy), .done(done), .legal(legal),
        .dir_mask(dir_mask), .timeout_err(timeout_err), .vld_ld(vld_ld),
        .vld_step(vld_step), .vld_start(vld_start), .vld_status(vld_status),
        .vld_done(vld_done), .vld_addr(vld_addr), .vld_wren(vld_wren),
        .host_req(host_req), .host_addr(host_addr), .host_wren(host_wren),
        .host_grant(host_grant), .mem_addr(mem_addr), .mem_wren(mem_wren),
        .mem_data(mem_data)
    );

    // Board RAM model with one-cycle read latency.
    logic [1:0] ram [128];
    always @(posedge clock) mem_data <= ram[mem_addr];

    // Validator model: answers LAT cycles after vld_start unless that
    // direction is configured to hang.
    logic [7:0] v_status = 8'h00;
    logic [7:0] v_hang   = 8'h00;
    logic [2:0] ld_cnt, cur_dir;
    int         wait_cnt;
    always @(posedge clock) begin
        if (!reset) begin
            vld_done <= 1'b0; vld_status <= 1'b0;
            ld_cnt <= 3'd0; cur_dir <= 3'd0; wait_cnt <= 0;
        end else begin
            vld_done <= 1'b0;
            if (!busy) ld_cnt <= 3'd0;
            else if (vld_ld) begin
                cur_dir <= ld_cnt;
                ld_cnt  <= ld_cnt + 3'd1;
            end
            if (vld_start && !v_hang[cur_dir]) wait_cnt <= LAT - 1;
            else if (wait_cnt != 0) begin
                wait_cnt <= wait_cnt - 1;
                if (wait_cnt == 1) begin
                    vld_done   <= 1'b1;
                    vld_status <= v_status[cur_dir];
                end
            end
        end
    end

    typedef struct packed {
        logic [7:0] mask;
        logic       lgl;
        logic       terr;
        logic [7:0] lat;
    } exp_t;

    exp_t       exp_q [$];
    logic [6:0] step_q [$];
    logic [6:0] steps [8] = '{7'd117, 7'd118, 7'd119, 7'd127, 7'd1, 7'd9, 7'd10, 7'd11};

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Monitor: pops the scoreboard on every vld_ld and done pulse.
    int   cyc = 0, acc_cyc = 0, done_cnt = 0, grant_viol = 0;
    logic prev_busy = 1'b0;
    always @(negedge clock) begin
        exp_t       e;
        logic [6:0] s;
        cyc++;
        if (busy && !prev_busy) begin
            acc_cyc = cyc;
            check_eq("accept_mask_clear", dir_mask, 0);
            check_eq("accept_legal_clear", legal, 0);
            check_eq("accept_terr_clear", timeout_err, 0);
        end
        prev_busy = busy;
        if (busy && host_grant) grant_viol++;
        if (vld_ld) begin
            if (step_q.size() == 0) check_eq("unexpected_ld", vld_ld, 0);
            else begin
                s = step_q.pop_front();
                check_eq("vld_step", vld_step, s);
            end
        end
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) check_eq("unexpected_done", done, 0);
            else begin
                e = exp_q.pop_front();
                $display("scan done: mask=%02h legal=%0d timeout_err=%0d latency=%0d",
                         dir_mask, legal, timeout_err, cyc - acc_cyc + 1);
                check_eq("dir_mask", dir_mask, e.mask);
                check_eq("legal", legal, e.lgl);
                check_eq("timeout_err", timeout_err, e.terr);
                check_eq("latency", cyc - acc_cyc + 1, e.lat);
            end
        end
    end

    // Queue the expected outcome of a scan, then pulse start.
    task automatic do_scan(input logic [6:0] a, input logic [7:0] st, input logic [7:0] hg);
        exp_t e;
        int   lat;
        v_status = st;
        v_hang   = hg;
        if (ram[a] != 2'b00) begin
            e.mask = 8'h00; e.lgl = 1'b0; e.terr = 1'b0; e.lat = 8'd3;
        end else begin
            lat = 3;
            for (int i = 0; i < 8; i++) begin
                step_q.push_back(steps[i]);
                lat += 3 + (hg[i] ? TMO : LAT);
            end
            e.mask = st & ~hg;
            e.lgl  = |(st & ~hg);
            e.terr = |hg;
            e.lat  = 8'(lat);
        end
        exp_q.push_back(e);
        @(negedge clock);
        start  = 1'b1;
        s_addr = a;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check_eq("done_seen", done_cnt != d0, 1);
    endtask

    task automatic wait_pulses(input int want_ld, input int want_st, input int budget);
        int nl = 0, ns = 0, k = 0;
        while ((nl < want_ld || ns < want_st) && k < budget) begin
            @(negedge clock);
            if (vld_ld) nl++;
            if (vld_start) ns++;
            k++;
        end
        check_eq("pulse_wait", (nl >= want_ld) && (ns >= want_st), 1);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 128; i++) ram[i] = 2'b00;
        reset = 1'b0; start = 1'b1; s_addr = 7'd44; player = 1'b0;
        vld_addr = 7'd3; vld_wren = 1'b1;
        host_req = 1'b1; host_addr = 7'd5; host_wren = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_legal", legal, 0);
        check_eq("rst_mask", dir_mask, 0);
        check_eq("rst_terr", timeout_err, 0);
        check_eq("rst_vld_ld", vld_ld, 0);
        check_eq("rst_vld_start", vld_start, 0);
        check_eq("rst_vld_step", vld_step, 0);
        check_eq("rst_grant", host_grant, 0);
        check_eq("rst_wren", mem_wren, 0);
        start = 1'b0; host_req = 1'b0; host_wren = 1'b0; reset = 1'b1;
        repeat (4) @(negedge clock);
        check_eq("pending_discarded", busy, 0);

        // Occupied square.
        ram[44] = 2'b01;
        do_scan(7'd44, 8'hFF, 8'h00);
        wait_done(20);

        // Empty square, only direction 4 captures.
        ram[44] = 2'b00;
        do_scan(7'd44, 8'h10, 8'h00);
        wait_done(100);

        // Host contention.
        host_req = 1'b1; host_addr = 7'd33; host_wren = 1'b1;
        do_scan(7'd55, 8'h81, 8'h00);
        repeat (4) @(negedge clock);
        check_eq("host_hold_busy", busy, 0);
        check_eq("host_hold_grant", host_grant, 1);
        check_eq("host_hold_addr", mem_addr, 33);
        check_eq("host_hold_wren", mem_wren, 1);
        host_req = 1'b0;
        @(negedge clock);
        check_eq("host_drop_busy", busy, 1);
        check_eq("host_drop_addr", mem_addr, 55);
        check_eq("host_drop_grant", host_grant, 0);
        host_req = 1'b1;
        @(negedge clock);
        check_eq("scan_wren", mem_wren, 0);
        wait_done(100);
        host_req = 1'b0; host_wren = 1'b0;

        // Timeout on direction 2, then a clean scan clears the flag.
        do_scan(7'd44, 8'h0C, 8'h04);
        wait_done(200);
        do_scan(7'd44, 8'h01, 8'h00);
        wait_done(100);

        // Reset during WAIT of direction 5.
        do_scan(7'd44, 8'hFF, 8'h00);
        wait_pulses(0, 6, 200);
        @(negedge clock);
        reset = 1'b0;
        d0 = done_cnt;
        step_q.delete();
        exp_q.delete();
        @(negedge clock);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_mask", dir_mask, 0);
        check_eq("midrst_done", done, 0);
        reset = 1'b1;
        repeat (50) @(negedge clock);
        check_eq("midrst_no_done", done_cnt - d0, 0);
        do_scan(7'd44, 8'h5A, 8'h00);
        wait_done(100);

        // start while busy is ignored.
        ram[20] = 2'b00;
        d0 = done_cnt;
        do_scan(7'd44, 8'h22, 8'h00);
        wait_pulses(4, 0, 200);
        start = 1'b1; s_addr = 7'd20;
        @(negedge clock);
        start = 1'b0;
        wait_done(100);
        repeat (60) @(negedge clock);
        check_eq("single_done", done_cnt - d0, 1);
        check_eq("idle_after", busy, 0);

        check_eq("step_q_empty", step_q.size(), 0);
        check_eq("exp_q_empty", exp_q.size(), 0);
        check_eq("grant_in_scan", grant_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
